// File: rtl/neurocam_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : neurocam_cmd_framer
// Purpose  : Assembles nibble traffic into opcode/pattern/address commands and
//            buffers completed commands for the CAM core.
// Revision : 1.0
// ============================================================================
module neurocam_cmd_framer #(
    parameter int PATTERN_WIDTH  = 16,
    parameter int ADDR_WIDTH     = 6,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          nib_valid,
    input  logic [3:0]                    nib_data,
    input  logic [1:0]                    nib_idx,
    input  logic [1:0]                    nib_op,
    input  logic [ADDR_WIDTH-1:0]         nib_addr,
    output logic                          nib_ready,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [1:0]                    cmd_op,
    output logic [PATTERN_WIDTH-1:0]      cmd_pattern,
    output logic [ADDR_WIDTH-1:0]         cmd_addr,
    output logic                          frame_err,
    output logic [7:0]                    err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + PATTERN_WIDTH + ADDR_WIDTH;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       TMO_LAST   = 4'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       OP_RSVD    = 2'b11;

    typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    state_t                    state, state_nxt;
    logic [1:0]                exp_idx, exp_idx_nxt;
    logic [1:0]                op_q, op_nxt;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_nxt;
    logic [PATTERN_WIDTH-1:0]  pat_q, pat_nxt;
    logic [3:0]                tmo_q, tmo_nxt;
    logic                      err_nxt;
    logic                      push;
    logic                      pop;
    logic                      accept;
    logic [ENTRY_W-1:0]        push_entry;
    logic [ENTRY_W-1:0]        head;
    logic [ENTRY_W-1:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;

    assign nib_ready = (fifo_count != FULL_COUNT);
    assign accept    = nib_valid && nib_ready;
    assign cmd_valid = (fifo_count != '0);
    assign pop       = cmd_valid && cmd_ready;
    // The completing nibble is folded straight into the pushed entry.
    assign push_entry = {op_q, nib_data, pat_q[PATTERN_WIDTH-5:0], addr_q};

    always_comb begin
        state_nxt   = state;
        exp_idx_nxt = exp_idx;
        op_nxt      = op_q;
        addr_nxt    = addr_q;
        pat_nxt     = pat_q;
        tmo_nxt     = tmo_q;
        err_nxt     = 1'b0;
        push        = 1'b0;
        case (state)
            IDLE: begin
                tmo_nxt = '0;
                if (accept) begin
                    if (nib_idx == 2'd0) begin
                        op_nxt       = nib_op;
                        addr_nxt     = nib_addr;
                        pat_nxt[3:0] = nib_data;
                        exp_idx_nxt  = 2'd1;
                        state_nxt    = COLLECT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    tmo_nxt = '0;
                    if (nib_idx == exp_idx) begin
                        pat_nxt[{nib_idx, 2'b00} +: 4] = nib_data;
                        exp_idx_nxt = exp_idx + 2'd1;
                        if (nib_idx == 2'd3) begin
                            state_nxt = IDLE;
                            if (op_q == OP_RSVD) err_nxt = 1'b1;
                            else                 push    = 1'b1;
                        end
                    end else if (nib_idx == 2'd0) begin
                        err_nxt      = 1'b1;
                        op_nxt       = nib_op;
                        addr_nxt     = nib_addr;
                        pat_nxt[3:0] = nib_data;
                        exp_idx_nxt  = 2'd1;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (!nib_valid) begin
                    if (tmo_q == TMO_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                        tmo_nxt   = '0;
                    end else begin
                        tmo_nxt = tmo_q + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exp_idx   <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            pat_q     <= '0;
            tmo_q     <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            exp_idx   <= exp_idx_nxt;
            op_q      <= op_nxt;
            addr_q    <= addr_nxt;
            pat_q     <= pat_nxt;
            tmo_q     <= tmo_nxt;
            frame_err <= err_nxt;
            if (err_nxt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head        = cmd_valid ? mem[rd_ptr] : '0;
    assign cmd_op      = head[ENTRY_W-1 -: 2];
    assign cmd_pattern = head[ADDR_WIDTH +: PATTERN_WIDTH];
    assign cmd_addr    = head[ADDR_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_neurocam_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_neurocam_cmd_framer
// Purpose  : Directed and random stimulus against a frame-level reference
//            model, with a scoreboard monitor sampling on the falling edge.
// Revision : 1.0
// ============================================================================
module tb_neurocam_cmd_framer;

    localparam int TIMEOUT = 12;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nib_valid = 1'b0;
    logic [3:0]  nib_data = '0;
    logic [1:0]  nib_idx = '0;
    logic [1:0]  nib_op = '0;
    logic [5:0]  nib_addr = '0;
    logic        nib_ready;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_pattern;
    logic [5:0]  cmd_addr;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [2:0]  fifo_count;

    neurocam_cmd_framer dut (
        .clk(clk), .rst_n(rst_n),
        .nib_valid(nib_valid), .nib_data(nib_data), .nib_idx(nib_idx),
        .nib_op(nib_op), .nib_addr(nib_addr), .nib_ready(nib_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_pattern(cmd_pattern), .cmd_addr(cmd_addr),
        .frame_err(frame_err), .err_count(err_count), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    bit mon_en = 1'b0;

    // Reference model: nibbles gathered so far in the open frame (0 = none).
    int          m_have = 0;
    int          m_idle = 0;
    int          m_cnt = 0;
    int          m_errcnt = 0;
    bit          m_err = 1'b0;
    logic [1:0]  m_op = '0;
    logic [5:0]  m_addr = '0;
    logic [15:0] m_pat = '0;
    logic [23:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_idle = 0; m_cnt = 0; m_errcnt = 0; m_err = 1'b0;
        m_op = '0; m_addr = '0; m_pat = '0;
        q.delete();
    endtask

    task automatic start_frame();
        m_have = 1;
        m_op   = nib_op;
        m_addr = nib_addr;
        m_pat  = {12'h000, nib_data};
    endtask

    task automatic model_step();
        bit acc;
        bit e;
        bit p;
        int sh;
        acc = nib_valid && (m_cnt != DEPTH);
        e = 1'b0;
        p = 1'b0;
        if (acc) begin
            m_idle = 0;
            if (m_have == 0) begin
                if (nib_idx == 2'd0) start_frame();
                else e = 1'b1;
            end else if (int'(nib_idx) == m_have) begin
                sh = 4 * m_have;
                m_pat = m_pat | (16'(nib_data) << sh);
                m_have++;
                if (m_have == 4) begin
                    m_have = 0;
                    if (m_op == 2'd3) e = 1'b1;
                    else p = 1'b1;
                end
            end else if (nib_idx == 2'd0) begin
                e = 1'b1;
                start_frame();
            end else begin
                e = 1'b1;
                m_have = 0;
            end
        end else if (m_have != 0 && !nib_valid) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                e = 1'b1;
                m_have = 0;
                m_idle = 0;
            end
        end
        if (cmd_ready && m_cnt > 0) m_cnt--;
        if (p) begin
            m_cnt++;
            q.push_back({m_op, m_pat, m_addr});
        end
        m_err = e;
        if (e && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic send(input logic [1:0] idx, input logic [3:0] d,
                        input logic [1:0] op, input logic [5:0] a);
        bit acc;
        int n;
        n = 0;
        nib_valid = 1'b1; nib_idx = idx; nib_data = d; nib_op = op; nib_addr = a;
        do begin
            acc = (m_cnt != DEPTH);
            step();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL send_wait: nibble idx %0d not accepted within 200 cycles", idx);
        end
        nib_valid = 1'b0;
    endtask

    task automatic frame(input logic [1:0] op, input logic [5:0] a, input logic [15:0] pat);
        for (int i = 0; i < 4; i++) send(2'(i), pat[4*i +: 4], op, a);
    endtask

    task automatic idle(input int n);
        nib_valid = 1'b0;
        repeat (n) step();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("nib_ready", nib_ready, m_cnt != DEPTH);
            chk("fifo_count", fifo_count, m_cnt);
            chk("cmd_valid", cmd_valid, m_cnt != 0);
            chk("frame_err", frame_err, m_err);
            chk("err_count", err_count, m_errcnt);
            if (cmd_valid) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL scb_head: got %0h expected no command", {cmd_op, cmd_pattern, cmd_addr});
                end else begin
                    chk("cmd_head", {cmd_op, cmd_pattern, cmd_addr}, q[0]);
                    if (cmd_ready) void'(q.pop_front());
                end
            end else begin
                chk("cmd_idle_zero", {cmd_op, cmd_pattern, cmd_addr}, 0);
            end
        end
    end

    initial begin
        repeat (3) step();
        chk("rst_nib_ready", nib_ready, 1);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_fields", {cmd_op, cmd_pattern, cmd_addr}, 0);
        chk("rst_err", {frame_err, err_count, fifo_count}, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        cmd_ready = 1'b1;

        // Basic frame, then idle so it drains.
        frame(2'b00, 6'h15, 16'hC3A5);
        idle(3);

        // Fill the FIFO, stall a fifth frame, then drain.
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) frame(2'b01, 6'(i + 8), 16'(16'h1111 * (i + 1)));
        nib_valid = 1'b1; nib_idx = 2'd0; nib_data = 4'h7; nib_op = 2'b01; nib_addr = 6'h2A;
        repeat (20) step();
        cmd_ready = 1'b1;
        frame(2'b01, 6'h2A, 16'hBEE7);
        idle(8);

        // Skipped index, then a clean frame.
        send(2'd0, 4'h1, 2'b10, 6'h01);
        send(2'd1, 4'h2, 2'b10, 6'h01);
        send(2'd3, 4'h3, 2'b10, 6'h01);
        frame(2'b10, 6'h3F, 16'h9E01);
        idle(3);

        // Mid-frame timeout, then an orphan index; then restart via idx 0.
        send(2'd0, 4'h4, 2'b00, 6'h22);
        idle(TIMEOUT + 2);
        send(2'd1, 4'h5, 2'b00, 6'h22);
        send(2'd0, 4'h6, 2'b00, 6'h23);
        send(2'd1, 4'h7, 2'b00, 6'h23);
        frame(2'b00, 6'h24, 16'h0F0F);
        idle(3);

        // Reserved opcode, then saturate the error counter.
        frame(2'b11, 6'h10, 16'h1234);
        for (int i = 0; i < 260; i++) send(2'd2, 4'h0, 2'b00, 6'h00);
        idle(2);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                idle(TIMEOUT + 1);
            end else begin
                nib_valid = ($urandom_range(0, 9) < 7);
                nib_idx   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_have);
                nib_data  = 4'($urandom());
                nib_op    = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                nib_addr  = 6'($urandom());
                step();
            end
        end
        nib_valid = 1'b0;
        cmd_ready = 1'b1;
        idle(8);

        // Asynchronous reset mid-frame with two entries buffered.
        cmd_ready = 1'b0;
        frame(2'b01, 6'h05, 16'hA0A0);
        frame(2'b10, 6'h06, 16'h5A5A);
        send(2'd0, 4'hD, 2'b00, 6'h07);
        send(2'd1, 4'hE, 2'b00, 6'h07);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_nib_ready", nib_ready, 1);
        chk("arst_cmd_valid", cmd_valid, 0);
        chk("arst_fields", {cmd_op, cmd_pattern, cmd_addr}, 0);
        chk("arst_err", {frame_err, err_count, fifo_count}, 0);
        model_reset();
        repeat (2) step();
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        cmd_ready = 1'b1;
        frame(2'b00, 6'h2B, 16'h4321);
        idle(4);

        chk("scb_drained", q.size(), 0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
